window_assembler: RTL
=====================

# window_assembler

Downstream stage of the three per-row byte FIFOs in the input layer. Each FIFO presents a 24-bit, 3-pixel slice of one image row. This block pops all three rows in lockstep and assembles 72-bit 3x3 windows onto a valid/ready stream for the processing stage. It counts columns and rows, and clears the FIFOs at every row boundary via `one_row_complete`.

## Interface
- `IMG_WIDTH`, 8: pixels per row; must be ≥ 3. Windows per row = `IMG_WIDTH-2`.
- `IMG_HEIGHT`, 8: rows per image; must be ≥ 3. Window rows per image = `IMG_HEIGHT-2`.

- `clk` in 1: single clock. All logic is rising-edge.
- `reset` in 1: synchronous, active-high.
- `start` in 1: one-cycle pulse that begins an image. Ignored unless in IDLE.
- `row0_data`, `row1_data`, `row2_data` in 24 each: FIFO `data_o` outputs. Byte 0 is the leftmost pixel. Row0 is the top row.
- `row0_count`, `row1_count`, `row2_count` in 4 each: FIFO occupancy in bytes.
- `pop` out 1: drives the `pop` input of all three FIFOs.
- `one_row_complete` out 1: one-cycle pulse to all three FIFOs at a row boundary.
- `window_data` out 72: bits [23:0] are row0, [47:24] are row1, [71:48] are row2.
- `window_valid` out 1: output stream valid.
- `window_ready` in 1: output stream ready.
- `busy` out 1: high in any state other than IDLE.
- `done` out 1: one-cycle pulse after the last window row of the image is released.

## Operation
- The FSM has four states: IDLE, RUN, ROW_END, DONE.
- **IDLE**
  - On `start`, go to RUN. Clear `col_cnt` and `row_cnt`.
- **RUN**
  - Define `avail` = all three counts ≥ 3.
  - Define `slot` = `!window_valid || window_ready`.
  - Define `capture` = `avail && slot`. `capture` is combinational.
  - `pop` = `capture`, in the same cycle.
  - On capture:
    - `window_data <= {row2_data,row1_data,row0_data}`.
    - `window_valid <= 1`.
    - `col_cnt <= col_cnt+1`.
  - If `capture` and `col_cnt == IMG_WIDTH-3`, this is the last window of the row. Go to ROW_END and clear `col_cnt`.
- **ROW_END**
  - Assert `one_row_complete` for exactly this cycle. `pop` = 0.
  - If `row_cnt == IMG_HEIGHT-3`, go to DONE. Otherwise increment `row_cnt` and return to RUN.
- **DONE**
  - Wait until `window_valid` = 0 or `window_ready` = 1, i.e. the last window is drained.
  - Then pulse `done` for one cycle and go to IDLE.
- **Output register**
  - When `window_valid && window_ready && !capture`, clear `window_valid` at the next edge.
  - `window_data` holds its value while `window_valid && !window_ready`.
- Width rules: `col_cnt` and `row_cnt` are `$clog2` of their maximum + 1, unsigned. The comparisons above are exact.

## Timing
- Reset values: every output is 0 (`pop`, `one_row_complete`, `window_data`, `window_valid`, `busy`, `done`). The state is IDLE and both counters are 0.
- Reset mid-operation returns to IDLE on the next edge. Any pending window is dropped. `one_row_complete` is not issued.
- Latency: row data present with `avail` at edge N gives `window_valid` high after edge N, when `slot` holds.
- Throughput: one window per cycle with `window_ready` held high.
- FIFO data refreshes one cycle after `pop`. Because FIFO counts update after the edge, back-to-back pops rely only on registered counts.
- Backpressure: with `window_valid=1` and `window_ready=0`, `pop` = 0 and the FIFOs are untouched.
- Any count < 3 in RUN means a stall with no pop. `window_valid` may still drain.
- Simultaneous accept and capture: `window_valid` stays 1 and `window_data` updates.
- The ROW_END cycle never pops. After it, the FIFOs report count 0 until upstream refills them.
- `start` during `busy` is ignored.

## Structure
- Shared package `input_layer_pkg` holds:
  - the FSM state encoding (IDLE=0, RUN=1, ROW_END=2, DONE=3);
  - `PIX_W`=8, `WIN_PIX`=3, and the derived `ROW_SLICE_W`=24 and `WIN_W`=72.
- One natural sub-module is `win_out_reg`: a single-entry valid/ready register slice holding `window_data` and `window_valid`, exposing `slot`.
- The top level holds the FSM and the counters.

## Test plan
- **Basic row.** Reset, then `start`. All counts = 8. FIFO models hold rows 0x00..0x07, 0x10..0x17, 0x20..0x27. `window_ready`=1.
  - Expect 6 windows. The first is 72'h222120_121110_020100.
  - Expect 6 `pop` pulses, then one `one_row_complete`.
- **Backpressure.** Hold `window_ready`=0 for 5 cycles after the first window.
  - Expect `window_data` stable, `pop`=0 throughout, and no window lost or duplicated.
- **Starvation.** Hold `row1_count`=2 for 4 cycles mid-row.
  - Expect `pop`=0 and no new window. Capture resumes the cycle the count reaches 3.
- **Full image.** 8x8 image.
  - Expect 36 windows, 6 `one_row_complete` pulses, and a `done` pulse after the last handshake. `busy` returns to 0.
- **Reset mid-row.** Assert `reset` after the 3rd window.
  - Expect all outputs at 0 and state IDLE. A new `start` restarts at `col_cnt`=0.
- **Start while busy.** Pulse `start` in RUN.
  - Expect no effect on counters or output sequence.

Source files
------------

// File: rtl/input_layer_pkg.sv
// Shared definitions for the input layer: window geometry and the
// window_assembler state encoding.
package input_layer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RUN     = 2'd1,
    ST_ROW_END = 2'd2,
    ST_DONE    = 2'd3
  } wa_state_e;

  localparam int PIX_W       = 8;
  localparam int WIN_PIX     = 3;
  localparam int ROW_SLICE_W = PIX_W * WIN_PIX;
  localparam int WIN_W       = ROW_SLICE_W * WIN_PIX;
  localparam int FIFO_CNT_W  = 4;

  // Counter width able to hold 0..max_val; never narrower than one bit.
  function automatic int cnt_w(input int max_val);
    return (max_val > 0) ? $clog2(max_val + 1) : 1;
  endfunction

endpackage

// File: rtl/win_out_reg.sv
// Single-entry valid/ready register slice holding the assembled window.
// slot is high whenever a new window may be loaded this cycle.
module win_out_reg
  import input_layer_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [WIN_W-1:0] load_data,
  input  logic             ready,
  output logic [WIN_W-1:0] data,
  output logic             valid,
  output logic             slot
);

  logic [WIN_W-1:0] data_q, data_d;
  logic             valid_q, valid_d;

  // A load in the same cycle as an accept keeps valid high with new data.
  always_comb begin
    data_d  = data_q;
    valid_d = valid_q;
    if (load) begin
      data_d  = load_data;
      valid_d = 1'b1;
    end else if (valid_q && ready) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      data_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      data_q  <= data_d;
      valid_q <= valid_d;
    end
  end

  assign data  = data_q;
  assign valid = valid_q;
  assign slot  = !valid_q || ready;

endmodule

// File: rtl/window_assembler.sv
// Pops the three row FIFOs in lockstep and emits 3x3 windows on a
// valid/ready stream, clearing the FIFOs at every row boundary.
module window_assembler
  import input_layer_pkg::*;
#(
  parameter int IMG_WIDTH  = 8,
  parameter int IMG_HEIGHT = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic [ROW_SLICE_W-1:0] row0_data,
  input  logic [ROW_SLICE_W-1:0] row1_data,
  input  logic [ROW_SLICE_W-1:0] row2_data,
  input  logic [FIFO_CNT_W-1:0]  row0_count,
  input  logic [FIFO_CNT_W-1:0]  row1_count,
  input  logic [FIFO_CNT_W-1:0]  row2_count,
  output logic                   pop,
  output logic                   one_row_complete,
  output logic [WIN_W-1:0]       window_data,
  output logic                   window_valid,
  input  logic                   window_ready,
  output logic                   busy,
  output logic                   done
);

  localparam int COL_MAX = IMG_WIDTH - 3;
  localparam int ROW_MAX = IMG_HEIGHT - 3;
  localparam int COL_W   = cnt_w(COL_MAX);
  localparam int ROW_W   = cnt_w(ROW_MAX);
  localparam logic [COL_W-1:0] COL_LAST = COL_W'(COL_MAX);
  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(ROW_MAX);

  wa_state_e        state_q, state_d;
  logic [COL_W-1:0] col_cnt_q, col_cnt_d;
  logic [ROW_W-1:0] row_cnt_q, row_cnt_d;

  logic [WIN_PIX-1:0][ROW_SLICE_W-1:0] rows;
  logic [WIN_PIX-1:0][FIFO_CNT_W-1:0]  fill;
  logic [WIN_PIX-1:0]                  row_avail;
  logic                                avail;
  logic                                slot;
  logic                                capture;

  // Index 0 lands in the low bits, so the packed rows are the window layout.
  assign rows = {row2_data, row1_data, row0_data};
  assign fill = {row2_count, row1_count, row0_count};

  for (genvar r = 0; r < WIN_PIX; r++) begin : g_row
    assign row_avail[r] = fill[r] >= FIFO_CNT_W'(WIN_PIX);
  end

  assign avail   = &row_avail;
  assign capture = (state_q == ST_RUN) && avail && slot;

  win_out_reg u_out (
    .clk       (clk),
    .reset     (reset),
    .load      (capture),
    .load_data (rows),
    .ready     (window_ready),
    .data      (window_data),
    .valid     (window_valid),
    .slot      (slot)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      col_cnt_q <= '0;
      row_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      col_cnt_q <= col_cnt_d;
      row_cnt_q <= row_cnt_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    col_cnt_d = col_cnt_q;
    row_cnt_d = row_cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d   = ST_RUN;
          col_cnt_d = '0;
          row_cnt_d = '0;
        end
      end
      ST_RUN: begin
        if (capture) begin
          if (col_cnt_q == COL_LAST) begin
            col_cnt_d = '0;
            state_d   = ST_ROW_END;
          end else begin
            col_cnt_d = col_cnt_q + COL_W'(1);
          end
        end
      end
      ST_ROW_END: begin
        if (row_cnt_q == ROW_LAST) begin
          state_d = ST_DONE;
        end else begin
          row_cnt_d = row_cnt_q + ROW_W'(1);
          state_d   = ST_RUN;
        end
      end
      ST_DONE: begin
        // Hold until the final window has left the output slice.
        if (slot) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    pop              = capture;
    one_row_complete = (state_q == ST_ROW_END);
    done             = (state_q == ST_DONE) && slot;
    busy             = (state_q != ST_IDLE);
  end

endmodule
